// File: rtl/srl_fifo_pkg.sv
// Shared helpers for the SRL-backed FWFT FIFO controller and its storage.
package srl_fifo_pkg;

    function automatic int cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

    // Legal capacity: at least two words, and every slot must be addressable.
    function automatic bit depth_ok(input int depth, input int addr_width);
        return (depth >= 2) && (depth <= (1 << addr_width));
    endfunction

    // Occupancy at the widest supported address width; blocks narrow it locally.
    localparam int MAX_ADDR_WIDTH = 16;
    typedef logic [MAX_ADDR_WIDTH:0] occ_max_t;

endpackage

// File: rtl/srl_fifo_storage.sv
// DEPTH x DATA_WIDTH shift-register storage: din shifts into slot 0, dout reads slot addr.
module srl_fifo_storage
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q;

    // Data only: no reset, matching the SRL primitive.
    always_ff @(posedge clk) begin
        if (we_i) sr_q <= {sr_q[DEPTH-2:0], din_i};
    end

    always_comb begin
        dout_o = '0;
        if (int'(addr_i) < DEPTH) dout_o = sr_q[addr_i];
    end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// First-word-fall-through control around SRL storage with registered full/empty flags.
// Optional SRL_FIFO_CTRL_LEVEL_EN exposes occupancy (if_num_data_valid) and capacity (if_fifo_cap).
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
`ifdef SRL_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
`endif
);

    localparam int  CNT_W    = cnt_w(ADDR_WIDTH);
    localparam bit  DEPTH_OK = depth_ok(DEPTH, ADDR_WIDTH);

    typedef logic [CNT_W-1:0] occ_t;

    if (!DEPTH_OK) begin : g_bad_depth
        $error("srl_fifo_ctrl: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
    end

    occ_t                  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  empty_n_q, full_n_q;
    logic                  push, pop;

    assign push = if_write & if_write_ce & full_n_q;
    assign pop  = if_read  & if_read_ce  & empty_n_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + occ_t'(1);
        else if (pop && !push) cnt_d = cnt_q - occ_t'(1);
        addr_d = '0;
        if (cnt_d != '0) addr_d = ADDR_WIDTH'(cnt_d - occ_t'(1));
    end

    // Flags follow the next occupancy so they are valid right after the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            empty_n_q <= (cnt_d != '0);
            full_n_q  <= (cnt_d != occ_t'(DEPTH));
        end
    end

    srl_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk    (clk),
        .we_i   (push),
        .addr_i (addr_q),
        .din_i  (if_din),
        .dout_o (if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;

`ifdef SRL_FIFO_CTRL_LEVEL_EN
    assign if_num_data_valid = cnt_q;
    assign if_fifo_cap       = occ_t'(DEPTH);
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl: DEPTH=4 and DEPTH=2 instances, vector table plus scoreboard queues.
module tb_srl_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_wr = 0, a_rd = 0, a_wce = 0, a_rce = 0;
    logic [7:0] a_din = '0;
    logic       a_full_n, a_empty_n;
    logic [7:0] a_dout;

    logic       b_wr = 0, b_rd = 0, b_wce = 0, b_rce = 0;
    logic [7:0] b_din = '0;
    logic       b_full_n, b_empty_n;
    logic [7:0] b_dout;

`ifdef SRL_FIFO_CTRL_LEVEL_EN
    logic [2:0] a_ndv, a_cap;
    logic [1:0] b_ndv, b_cap;
`endif

    always #5 clk = ~clk;

    srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset),
        .if_full_n(a_full_n), .if_write_ce(a_wce), .if_write(a_wr), .if_din(a_din),
        .if_empty_n(a_empty_n), .if_read_ce(a_rce), .if_read(a_rd), .if_dout(a_dout)
`ifdef SRL_FIFO_CTRL_LEVEL_EN
        , .if_num_data_valid(a_ndv), .if_fifo_cap(a_cap)
`endif
    );

    srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .if_full_n(b_full_n), .if_write_ce(b_wce), .if_write(b_wr), .if_din(b_din),
        .if_empty_n(b_empty_n), .if_read_ce(b_rce), .if_read(b_rd), .if_dout(b_dout)
`ifdef SRL_FIFO_CTRL_LEVEL_EN
        , .if_num_data_valid(b_ndv), .if_fifo_cap(b_cap)
`endif
    );

    typedef struct {
        bit         wr;
        logic [7:0] din;
        bit         rd;
        bit         wce;
        bit         rce;
        bit         exp_full_n;
        bit         exp_empty_n;
    } vec_t;

    vec_t       tbl [24];
    logic [7:0] q4 [$];
    logic [7:0] q2 [$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_level(input string nm);
`ifdef SRL_FIFO_CTRL_LEVEL_EN
        chk({nm, "_ndv_a"}, 32'(a_ndv), 32'(q4.size()));
        chk({nm, "_cap_a"}, 32'(a_cap), 32'd4);
        chk({nm, "_ndv_b"}, 32'(b_ndv), 32'(q2.size()));
        chk({nm, "_cap_b"}, 32'(b_cap), 32'd2);
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    // Called on a falling edge: drive one cycle, score it, and check after the next edge.
    task automatic step(input int d, input bit wr, input logic [7:0] din, input bit rd,
                        input bit wce, input bit rce, input bit efn, input bit een,
                        input string nm);
        int  sz, cap;
        bit  push, pop;
        if (d == 0) begin
            a_wr = wr; a_din = din; a_rd = rd; a_wce = wce; a_rce = rce;
            sz = q4.size(); cap = 4;
        end else begin
            b_wr = wr; b_din = din; b_rd = rd; b_wce = wce; b_rce = rce;
            sz = q2.size(); cap = 2;
        end
        push = wr && wce && (sz < cap);
        pop  = rd && rce && (sz > 0);
        if (pop) begin
            if (d == 0) chk({nm, "_popdata"}, 32'(a_dout), 32'(q4.pop_front()));
            else        chk({nm, "_popdata"}, 32'(b_dout), 32'(q2.pop_front()));
        end
        if (push) begin
            if (d == 0) q4.push_back(din);
            else        q2.push_back(din);
        end
        @(negedge clk);
        a_wr = 0; a_rd = 0; a_wce = 0; a_rce = 0;
        b_wr = 0; b_rd = 0; b_wce = 0; b_rce = 0;
        if (d == 0) begin
            chk({nm, "_full_n"},  32'(a_full_n),  32'(efn));
            chk({nm, "_empty_n"}, 32'(a_empty_n), 32'(een));
            if (q4.size() > 0) chk({nm, "_head"}, 32'(a_dout), 32'(q4[0]));
        end else begin
            chk({nm, "_full_n"},  32'(b_full_n),  32'(efn));
            chk({nm, "_empty_n"}, 32'(b_empty_n), 32'(een));
            if (q2.size() > 0) chk({nm, "_head"}, 32'(b_dout), 32'(q2[0]));
        end
        chk_level(nm);
    endtask

    initial begin
        //            wr  din    rd wce rce fn en
        tbl[0]  = '{1, 8'h0A, 0, 1, 1, 1, 1};
        tbl[1]  = '{1, 8'h0B, 0, 1, 1, 1, 1};
        tbl[2]  = '{1, 8'h0C, 0, 1, 1, 1, 1};
        tbl[3]  = '{1, 8'h0D, 0, 1, 1, 0, 1};
        tbl[4]  = '{1, 8'h0E, 0, 1, 1, 0, 1};  // push into full: ignored
        tbl[5]  = '{0, 8'h00, 1, 1, 1, 1, 1};
        tbl[6]  = '{0, 8'h00, 1, 1, 1, 1, 1};
        tbl[7]  = '{0, 8'h00, 1, 1, 1, 1, 1};
        tbl[8]  = '{0, 8'h00, 1, 1, 1, 1, 0};
        tbl[9]  = '{0, 8'h00, 1, 1, 1, 1, 0};  // pop from empty: ignored
        tbl[10] = '{1, 8'h01, 0, 1, 1, 1, 1};
        tbl[11] = '{1, 8'h02, 0, 1, 1, 1, 1};
        tbl[12] = '{1, 8'h03, 1, 1, 1, 1, 1};  // push+pop holds cnt at 2
        tbl[13] = '{1, 8'h03, 1, 1, 1, 1, 1};
        tbl[14] = '{1, 8'h03, 1, 1, 1, 1, 1};
        tbl[15] = '{0, 8'h00, 1, 1, 0, 1, 1};  // read CE low
        tbl[16] = '{0, 8'h00, 1, 1, 0, 1, 1};
        tbl[17] = '{0, 8'h00, 1, 1, 0, 1, 1};
        tbl[18] = '{1, 8'h77, 0, 0, 1, 1, 1};  // write CE low
        tbl[19] = '{1, 8'h77, 0, 0, 1, 1, 1};
        tbl[20] = '{1, 8'h77, 0, 0, 1, 1, 1};
        tbl[21] = '{1, 8'h88, 1, 0, 1, 1, 1};  // write frozen, read proceeds
        tbl[22] = '{1, 8'h09, 0, 1, 1, 1, 1};
        tbl[23] = '{1, 8'h0A, 0, 1, 1, 1, 1};

        @(negedge clk);
        @(negedge clk);
        chk("rst_empty_n_a", 32'(a_empty_n), 32'd0);
        chk("rst_full_n_a",  32'(a_full_n),  32'd1);
        chk("rst_empty_n_b", 32'(b_empty_n), 32'd0);
        chk("rst_full_n_b",  32'(b_full_n),  32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_empty_n_a", 32'(a_empty_n), 32'd0);
        chk("idle_full_n_a",  32'(a_full_n),  32'd1);
        chk_level("idle");

        // DEPTH=2: push blocked at full even with a concurrent pop, then retried.
        step(1, 1, 8'h11, 0, 1, 1, 1, 1, "d2_push1");
        step(1, 1, 8'h22, 0, 1, 1, 0, 1, "d2_push2");
        step(1, 1, 8'h33, 1, 1, 1, 1, 1, "d2_full_pushpop");
        step(1, 1, 8'h33, 0, 1, 1, 0, 1, "d2_retry");
        step(1, 0, 8'h00, 1, 1, 1, 1, 1, "d2_pop1");
        step(1, 0, 8'h00, 1, 1, 1, 1, 0, "d2_pop2");

        for (int i = 0; i < 24; i++)
            step(0, tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].wce, tbl[i].rce,
                 tbl[i].exp_full_n, tbl[i].exp_empty_n, $sformatf("vec%0d", i));

        chk("pre_rst_cnt3", 32'(q4.size()), 32'd3);
        reset = 1'b1;
        q4.delete();
        q2.delete();
        #1;
        chk("midrst_empty_n", 32'(a_empty_n), 32'd0);
        chk("midrst_full_n",  32'(a_full_n),  32'd1);
        chk_level("midrst");
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 8'h05, 0, 1, 1, 1, 1, "postrst_push");
        step(0, 0, 8'h00, 1, 1, 1, 1, 0, "postrst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
